mem_port_arbiter: RTL and testbench

//   Shares one single-port memory between the fetch port (instruction reads) and the memory-stage port (loads/stores) of the 5-stage core.

---
 rtl/mem_port_arbiter_if.sv | 53 +++++
 rtl/mem_port_arbiter.sv | 130 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, the memory-stage port, the shared memory bus and
// the hazard/status outputs of the memory port arbiter.
// Handshake: each core port raises x_req and holds it, with its payload
// stable, until the arbiter answers with a one-cycle x_done pulse.
// x_rdata is valid while x_done=1. On the memory side the arbiter holds
// mem_req and the mem_* payload stable until the memory answers with mem_ack,
// or until the arbiter gives up on a timeout. mem_ack is only meaningful
// while mem_req=1.
interface mem_port_arbiter_if;
    // fetch port
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_done;
    // memory-stage port
    logic        d_req;
    logic        d_we;
    logic [2:0]  d_size;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_done;
    // shared memory
    logic        mem_req;
    logic        mem_we;
    logic [2:0]  mem_size;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    // hazard unit and status
    logic        stall_f;
    logic        stall_m;
    logic        err;

    // core pipeline plus memory side: drives requests and memory responses
    modport master (
        output i_req, i_addr, d_req, d_we, d_size, d_addr, d_wdata,
               mem_rdata, mem_ack,
        input  i_rdata, i_done, d_rdata, d_done,
               mem_req, mem_we, mem_size, mem_addr, mem_wdata,
               stall_f, stall_m, err
    );

    // the arbiter itself
    modport slave (
        input  i_req, i_addr, d_req, d_we, d_size, d_addr, d_wdata,
               mem_rdata, mem_ack,
        output i_rdata, i_done, d_rdata, d_done,
               mem_req, mem_we, mem_size, mem_addr, mem_wdata,
               stall_f, stall_m, err
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and the memory
// stage. Data accesses win, but a streak counter caps how many data grants
// in a row may pass a waiting fetch. A busy access that sees no mem_ack for
// TIMEOUT cycles is aborted with zero read data and a sticky err flag.
module mem_port_arbiter #(
    parameter int         MAX_D_STREAK = 4,
    parameter int         TIMEOUT      = 64,
    parameter logic [2:0] SIZE_WORD    = 3'b010
) (
    input  logic                clk,
    input  logic                reset,
    mem_port_arbiter_if.slave   bus,
    output logic [1:0]          stateDbg
);
    localparam int STREAK_W = $clog2(MAX_D_STREAK + 1);
    localparam int TO_W     = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arbState_t;

    arbState_t           state;
    arbState_t           stateNext;
    logic [STREAK_W-1:0] streak;
    logic [TO_W-1:0]     toCnt;

    logic effI;
    logic effD;
    logic grantI;
    logic grantD;
    logic busy;
    logic lastWait;
    logic finish;

    assign stateDbg = state;

    // hazard-unit stalls: a port is stalled until the cycle its done pulse shows
    assign bus.stall_f = bus.i_req & ~bus.i_done;
    assign bus.stall_m = bus.d_req & ~bus.d_done;

    // grant decision and next state; a port in its done cycle is masked so a
    // request still held on that cycle is not served twice
    always_comb begin
        effI      = bus.i_req & ~bus.i_done;
        effD      = bus.d_req & ~bus.d_done;
        grantD    = 1'b0;
        grantI    = 1'b0;
        busy      = (state != IDLE);
        lastWait  = (toCnt == TO_W'(TIMEOUT - 1));
        finish    = busy & (bus.mem_ack | lastWait);
        stateNext = state;
        case (state)
            IDLE: begin
                if (effD && (!effI || (streak < STREAK_W'(MAX_D_STREAK)))) begin
                    grantD    = 1'b1;
                    stateNext = BUSY_D;
                end else if (effI) begin
                    grantI    = 1'b1;
                    stateNext = BUSY_I;
                end
            end
            BUSY_I, BUSY_D: begin
                if (finish) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    // state register, memory-side payload, completion pulses and counters
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            streak        <= '0;
            toCnt         <= '0;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_size  <= '0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.i_rdata   <= '0;
            bus.d_rdata   <= '0;
            bus.i_done    <= 1'b0;
            bus.d_done    <= 1'b0;
            bus.err       <= 1'b0;
        end else begin
            state      <= stateNext;
            bus.i_done <= 1'b0;
            bus.d_done <= 1'b0;

            if (grantD) begin
                bus.mem_req   <= 1'b1;
                bus.mem_we    <= bus.d_we;
                bus.mem_size  <= bus.d_size;
                bus.mem_addr  <= bus.d_addr;
                bus.mem_wdata <= bus.d_wdata;
                toCnt         <= '0;
                // only data grants that overtake a waiting fetch count
                streak        <= effI ? streak + 1'b1 : '0;
            end else if (grantI) begin
                bus.mem_req   <= 1'b1;
                bus.mem_we    <= 1'b0;
                bus.mem_size  <= SIZE_WORD;
                bus.mem_addr  <= bus.i_addr;
                bus.mem_wdata <= '0;
                toCnt         <= '0;
                streak        <= '0;
            end

            if (busy) begin
                if (finish) begin
                    // an ack on the terminal cycle is a normal completion
                    bus.mem_req <= 1'b0;
                    toCnt       <= '0;
                    if (state == BUSY_I) begin
                        bus.i_done  <= 1'b1;
                        bus.i_rdata <= bus.mem_ack ? bus.mem_rdata : '0;
                    end else begin
                        bus.d_done  <= 1'b1;
                        bus.d_rdata <= bus.mem_ack ? bus.mem_rdata : '0;
                    end
                    if (!bus.mem_ack) bus.err <= 1'b1;
                end else begin
                    toCnt <= toCnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. A small memory responder acks each
// access ackLat cycles into mem_req (ackLat=0: never acks) with memData.
// Each task drives one scenario at cycle granularity and checks outputs
// 1 ns after the rising edge.
module tb_mem_port_arbiter;
    localparam logic [2:0] SIZE_WORD = 3'b010;

    logic       clk;
    logic       reset;
    logic [1:0] stateDbg;
    int         nChecks;
    int         nFails;
    int         ackLat;
    logic [31:0] memData;
    int         reqAge;

    mem_port_arbiter_if bus ();

    mem_port_arbiter #(
        .MAX_D_STREAK (4),
        .TIMEOUT      (64),
        .SIZE_WORD    (SIZE_WORD)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus.slave),
        .stateDbg (stateDbg)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // memory responder
    always begin
        @(posedge clk);
        #1;
        if (bus.mem_req) begin
            if (ackLat != 0 && reqAge + 1 == ackLat) begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = memData;
            end else begin
                bus.mem_ack   = 1'b0;
                bus.mem_rdata = 32'hxxxx_xxxx;
            end
            reqAge++;
        end else begin
            bus.mem_ack   = 1'b0;
            bus.mem_rdata = 32'h0;
            reqAge        = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        nChecks++; if (stateDbg !== 2'd0) begin nFails++; $display("FAIL reset_state: got %0d want 0", stateDbg); end
        nChecks++; if (bus.mem_req !== 1'b0) begin nFails++; $display("FAIL reset_mem_req: got %b want 0", bus.mem_req); end
        nChecks++; if ({bus.i_done, bus.d_done, bus.err} !== 3'b000) begin nFails++; $display("FAIL reset_flags: got %b want 000", {bus.i_done, bus.d_done, bus.err}); end
        nChecks++; if ({bus.i_rdata, bus.d_rdata, bus.mem_addr, bus.mem_wdata} !== 128'h0) begin nFails++; $display("FAIL reset_data: got nonzero want 0"); end
        nChecks++; if ({bus.mem_we, bus.mem_size} !== 4'h0) begin nFails++; $display("FAIL reset_we_size: got %h want 0", {bus.mem_we, bus.mem_size}); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_fetch_single();
        ackLat = 1; memData = 32'hDEAD_BEEF;
        bus.i_req = 1'b1; bus.i_addr = 32'h100;
        #1;
        nChecks++; if (bus.stall_f !== 1'b1) begin nFails++; $display("FAIL f1_stall_f_req: got %b want 1", bus.stall_f); end
        tick();
        nChecks++; if (stateDbg !== 2'd1) begin nFails++; $display("FAIL f1_state: got %0d want 1", stateDbg); end
        nChecks++; if (bus.mem_req !== 1'b1) begin nFails++; $display("FAIL f1_mem_req: got %b want 1", bus.mem_req); end
        nChecks++; if (bus.mem_addr !== 32'h100) begin nFails++; $display("FAIL f1_mem_addr: got %h want 100", bus.mem_addr); end
        nChecks++; if ({bus.mem_we, bus.mem_size} !== {1'b0, SIZE_WORD}) begin nFails++; $display("FAIL f1_we_size: got %b want 0010", {bus.mem_we, bus.mem_size}); end
        nChecks++; if (bus.i_done !== 1'b0) begin nFails++; $display("FAIL f1_done_early: got %b want 0", bus.i_done); end
        tick();
        nChecks++; if (bus.i_done !== 1'b1) begin nFails++; $display("FAIL f1_i_done: got %b want 1", bus.i_done); end
        nChecks++; if (bus.i_rdata !== 32'hDEAD_BEEF) begin nFails++; $display("FAIL f1_i_rdata: got %h want deadbeef", bus.i_rdata); end
        nChecks++; if (bus.stall_f !== 1'b0) begin nFails++; $display("FAIL f1_stall_f_done: got %b want 0", bus.stall_f); end
        nChecks++; if (bus.mem_req !== 1'b0) begin nFails++; $display("FAIL f1_mem_req_drop: got %b want 0", bus.mem_req); end
        bus.i_req = 1'b0;
        tick();
        nChecks++; if ({bus.i_done, stateDbg} !== 3'b000) begin nFails++; $display("FAIL f1_idle_after: got %b want 000", {bus.i_done, stateDbg}); end
        nChecks++; if (bus.i_rdata !== 32'hDEAD_BEEF) begin nFails++; $display("FAIL f1_rdata_hold: got %h want deadbeef", bus.i_rdata); end
    endtask

    task automatic test_priority();
        ackLat = 1; memData = 32'h0000_1234;
        bus.i_req = 1'b1; bus.i_addr = 32'h300;
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_size = 3'b010;
        bus.d_addr = 32'h200; bus.d_wdata = 32'h55;
        tick();
        nChecks++; if (stateDbg !== 2'd2) begin nFails++; $display("FAIL p_state_d: got %0d want 2", stateDbg); end
        nChecks++; if ({bus.mem_we, bus.mem_wdata, bus.mem_addr} !== {1'b1, 32'h55, 32'h200}) begin nFails++; $display("FAIL p_d_payload: got we=%b wd=%h a=%h want 1 55 200", bus.mem_we, bus.mem_wdata, bus.mem_addr); end
        nChecks++; if ({bus.stall_f, bus.stall_m} !== 2'b11) begin nFails++; $display("FAIL p_stalls_busy: got %b want 11", {bus.stall_f, bus.stall_m}); end
        tick();
        nChecks++; if ({bus.d_done, bus.i_done} !== 2'b10) begin nFails++; $display("FAIL p_d_done: got %b want 10", {bus.d_done, bus.i_done}); end
        nChecks++; if ({bus.stall_f, bus.stall_m} !== 2'b10) begin nFails++; $display("FAIL p_stalls_ddone: got %b want 10", {bus.stall_f, bus.stall_m}); end
        bus.d_req = 1'b0; bus.d_we = 1'b0;
        tick();
        nChecks++; if (stateDbg !== 2'd1) begin nFails++; $display("FAIL p_state_i: got %0d want 1", stateDbg); end
        nChecks++; if ({bus.mem_we, bus.mem_wdata, bus.mem_addr} !== {1'b0, 32'h0, 32'h300}) begin nFails++; $display("FAIL p_i_payload: got we=%b wd=%h a=%h want 0 0 300", bus.mem_we, bus.mem_wdata, bus.mem_addr); end
        nChecks++; if (bus.stall_f !== 1'b1) begin nFails++; $display("FAIL p_stall_f_ibusy: got %b want 1", bus.stall_f); end
        tick();
        nChecks++; if ({bus.i_done, bus.i_rdata} !== {1'b1, 32'h1234}) begin nFails++; $display("FAIL p_i_done: got %b %h want 1 1234", bus.i_done, bus.i_rdata); end
        bus.i_req = 1'b0;
        tick();
    endtask

    // The fetch request is dropped in each data-done cycle and raised again
    // with the next data grant, so every data grant overtakes a pending fetch.
    task automatic test_streak();
        ackLat = 1; memData = 32'h5A5A_0000;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_size = 3'b010; bus.d_addr = 32'h400;
        bus.i_req = 1'b1; bus.i_addr = 32'h800;
        for (int n = 0; n < 4; n++) begin
            tick();
            nChecks++; if ({stateDbg, bus.mem_addr} !== {2'd2, 32'h400 + 32'(4 * n)}) begin nFails++; $display("FAIL s_dgrant%0d: got st=%0d a=%h want 2 %h", n, stateDbg, bus.mem_addr, 32'h400 + 32'(4 * n)); end
            tick();
            bus.i_req = 1'b0; bus.d_addr = 32'h404 + 32'(4 * n);
            tick();
            bus.i_req = 1'b1;
        end
        tick();
        nChecks++; if ({stateDbg, bus.mem_addr} !== {2'd1, 32'h800}) begin nFails++; $display("FAIL s_igrant: got st=%0d a=%h want 1 800", stateDbg, bus.mem_addr); end
        tick();
        nChecks++; if (bus.i_done !== 1'b1) begin nFails++; $display("FAIL s_i_done: got %b want 1", bus.i_done); end
        bus.i_req = 1'b0;
        tick();
        nChecks++; if ({stateDbg, bus.mem_addr} !== {2'd2, 32'h410}) begin nFails++; $display("FAIL s_dresume: got st=%0d a=%h want 2 410", stateDbg, bus.mem_addr); end
        tick();
        nChecks++; if ({bus.d_done, bus.d_rdata} !== {1'b1, 32'h5A5A_0000}) begin nFails++; $display("FAIL s_dresume_done: got %b %h want 1 5a5a0000", bus.d_done, bus.d_rdata); end
        bus.d_req = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
        ackLat = 0; memData = 32'h0;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h500;
        for (int c = 1; c <= 64; c++) tick();
        nChecks++; if ({bus.d_done, bus.mem_req, bus.err} !== 3'b010) begin nFails++; $display("FAIL t_before: got done,req,err=%b want 010", {bus.d_done, bus.mem_req, bus.err}); end
        tick();
        nChecks++; if ({bus.d_done, bus.mem_req} !== 2'b10) begin nFails++; $display("FAIL t_done: got done,req=%b want 10", {bus.d_done, bus.mem_req}); end
        nChecks++; if (bus.d_rdata !== 32'h0) begin nFails++; $display("FAIL t_rdata: got %h want 0", bus.d_rdata); end
        nChecks++; if (bus.err !== 1'b1) begin nFails++; $display("FAIL t_err: got %b want 1", bus.err); end
        bus.d_req = 1'b0;
        tick(); tick();
        nChecks++; if (bus.err !== 1'b1) begin nFails++; $display("FAIL t_err_sticky: got %b want 1", bus.err); end
        ackLat = 1; memData = 32'hCAFE_0001;
        bus.d_req = 1'b1; bus.d_addr = 32'h504;
        tick(); tick();
        nChecks++; if ({bus.d_done, bus.d_rdata} !== {1'b1, 32'hCAFE_0001}) begin nFails++; $display("FAIL t_next: got %b %h want 1 cafe0001", bus.d_done, bus.d_rdata); end
        bus.d_req = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        ackLat = 0;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h600;
        tick(); tick();
        reset = 1'b1;
        tick();
        nChecks++; if ({stateDbg, bus.mem_req, bus.d_done, bus.err} !== 5'b0) begin nFails++; $display("FAIL r_abort: got st=%0d req=%b done=%b err=%b want 0", stateDbg, bus.mem_req, bus.d_done, bus.err); end
        reset = 1'b0; ackLat = 1; memData = 32'h6666_0000;
        tick();
        nChecks++; if ({stateDbg, bus.mem_addr} !== {2'd2, 32'h600}) begin nFails++; $display("FAIL r_regrant: got st=%0d a=%h want 2 600", stateDbg, bus.mem_addr); end
        tick();
        nChecks++; if ({bus.d_done, bus.d_rdata} !== {1'b1, 32'h6666_0000}) begin nFails++; $display("FAIL r_done: got %b %h want 1 66660000", bus.d_done, bus.d_rdata); end
        bus.d_req = 1'b0;
        tick();
    endtask

    task automatic test_ack_terminal();
        ackLat = 64; memData = 32'h0BAD_F00D;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h700;
        for (int c = 1; c <= 64; c++) tick();
        nChecks++; if (bus.d_done !== 1'b0) begin nFails++; $display("FAIL a_before: got %b want 0", bus.d_done); end
        tick();
        nChecks++; if ({bus.d_done, bus.d_rdata} !== {1'b1, 32'h0BAD_F00D}) begin nFails++; $display("FAIL a_done: got %b %h want 1 0badf00d", bus.d_done, bus.d_rdata); end
        nChecks++; if (bus.err !== 1'b0) begin nFails++; $display("FAIL a_err: got %b want 0", bus.err); end
        bus.d_req = 1'b0;
        tick();
    endtask

    initial begin
        nChecks = 0; nFails = 0;
        ackLat = 1; memData = 32'h0; reqAge = 0;
        reset = 1'b1;
        bus.i_req = 1'b0; bus.i_addr = 32'h0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_size = 3'b0;
        bus.d_addr = 32'h0; bus.d_wdata = 32'h0;
        bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0;
        test_reset();
        test_fetch_single();
        test_priority();
        test_streak();
        test_timeout();
        test_reset_mid();
        test_ack_terminal();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
